// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data memory arbiter.
//   state_e    : dump engine FSM encoding (3 bits).
//   WORD_SHIFT : left shift that turns a word index into a byte address.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/data_mem_arbiter_dump_sequencer.sv
// Memory-dump engine: walks word indices 0..DEPTH-1, reads each word from the
// shared memory and presents it to the debug unit over valid/ready.
// Ports:
//   i_clock, i_reset        : clock, asynchronous active-high reset
//   i_dump_start            : start pulse (ignored while busy)
//   i_dump_ready            : debug unit accepts o_dump_data
//   i_dump_grant            : top-level arbiter grants the memory this cycle
//   i_mem_dataread          : synchronous read data from the memory
//   o_dump_req              : engine wants the memory (ISSUE state)
//   o_starved               : starvation counter has reached its limit
//   o_dump_addr             : byte address of the current word
//   o_dump_grant_taken      : request and grant coincide this cycle
//   o_dump_data/valid/busy/done : debug-side stream and status
module dump_sequencer
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_dump_start,
  input  logic                  i_dump_ready,
  input  logic                  i_dump_grant,
  input  logic [DATA_WIDTH-1:0] i_mem_dataread,
  output logic                  o_dump_req,
  output logic                  o_starved,
  output logic [DATA_WIDTH-1:0] o_dump_addr,
  output logic                  o_dump_grant_taken,
  output logic [DATA_WIDTH-1:0] o_dump_data,
  output logic                  o_dump_valid,
  output logic                  o_dump_busy,
  output logic                  o_dump_done
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        starve_cnt_q, starve_cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   idx_wide;

  // State, index, starvation counter and captured word registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      starve_cnt_q <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      starve_cnt_q <= starve_cnt_d;
      data_q       <= data_d;
    end
  end

  // Next-state logic. The starvation counter saturates so that once the
  // limit is hit the engine keeps winning until it actually gets a grant.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    starve_cnt_d = starve_cnt_q;
    data_d       = data_q;
    case (state_q)
      ST_IDLE: begin
        if (i_dump_start) begin
          state_d      = ST_ISSUE;
          idx_d        = '0;
          starve_cnt_d = '0;
        end
      end
      ST_ISSUE: begin
        if (i_dump_grant) begin
          starve_cnt_d = '0;
          state_d      = ST_CAPTURE;
        end else if (starve_cnt_q < LIMIT) begin
          starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        // Memory read data arrives the cycle after the granted address.
        data_d  = i_mem_dataread;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (i_dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Word index zero-extended and converted to a byte address.
  always_comb begin
    idx_wide              = '0;
    idx_wide[IDX_W-1:0]   = idx_q;
    o_dump_addr           = idx_wide << WORD_SHIFT;
  end

  assign o_dump_req         = (state_q == ST_ISSUE);
  assign o_starved          = (starve_cnt_q >= LIMIT);
  assign o_dump_grant_taken = o_dump_req && i_dump_grant;
  assign o_dump_data        = data_q;
  assign o_dump_valid       = (state_q == ST_HOLD);
  assign o_dump_busy        = (state_q != ST_IDLE);
  assign o_dump_done        = (state_q == ST_DONE);

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data memory between the MEM pipeline stage and
// the debug memory-dump engine. The pipeline wins unless the dump engine has
// been denied STARVE_LIMIT times in a row, in which case the pipeline is
// stalled for one cycle.
// Ports:
//   i_clock, i_reset                         : clock, async active-high reset
//   i_pipe_req/write/address/datawrite       : pipeline memory request
//   o_pipe_dataread, o_pipe_stall            : pipeline load data and stall
//   i_dump_start, i_dump_ready               : debug unit control
//   o_dump_data/valid/busy/done              : debug unit stream and status
//   o_mem_address/datawrite/memwrite         : to the memory
//   i_mem_dataread                           : from the memory (1-cycle read)
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_pipe_req,
  input  logic                  i_pipe_write,
  input  logic [DATA_WIDTH-1:0] i_pipe_address,
  input  logic [DATA_WIDTH-1:0] i_pipe_datawrite,
  output logic [DATA_WIDTH-1:0] o_pipe_dataread,
  output logic                  o_pipe_stall,
  input  logic                  i_dump_start,
  input  logic                  i_dump_ready,
  output logic [DATA_WIDTH-1:0] o_dump_data,
  output logic                  o_dump_valid,
  output logic                  o_dump_busy,
  output logic                  o_dump_done,
  output logic [DATA_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0] o_mem_datawrite,
  output logic                  o_mem_memwrite,
  input  logic [DATA_WIDTH-1:0] i_mem_dataread
);

  logic                  dump_req;
  logic                  starved;
  logic                  dump_grant;
  logic                  dump_grant_taken;
  logic [DATA_WIDTH-1:0] dump_addr;

  dump_sequencer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH       (DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_dump_sequencer (
    .i_clock           (i_clock),
    .i_reset           (i_reset),
    .i_dump_start      (i_dump_start),
    .i_dump_ready      (i_dump_ready),
    .i_dump_grant      (dump_grant),
    .i_mem_dataread    (i_mem_dataread),
    .o_dump_req        (dump_req),
    .o_starved         (starved),
    .o_dump_addr       (dump_addr),
    .o_dump_grant_taken(dump_grant_taken),
    .o_dump_data       (o_dump_data),
    .o_dump_valid      (o_dump_valid),
    .o_dump_busy       (o_dump_busy),
    .o_dump_done       (o_dump_done)
  );

  // The dump only wins an idle memory, or a busy one once it is starved;
  // in the latter case the pipeline is told to hold and retry.
  assign dump_grant   = dump_req && (!i_pipe_req || starved);
  assign o_pipe_stall = dump_req && i_pipe_req && starved;

  assign o_pipe_dataread = i_mem_dataread;

  // Memory mux. A stalled store never reaches the memory because a stall
  // always coincides with a dump grant, which forces a read.
  always_comb begin
    o_mem_address   = i_pipe_address;
    o_mem_datawrite = i_pipe_datawrite;
    o_mem_memwrite  = i_pipe_req && i_pipe_write;
    if (dump_grant_taken) begin
      o_mem_address   = dump_addr;
      o_mem_datawrite = '0;
      o_mem_memwrite  = 1'b0;
    end
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port data memory between the MEM pipeline stage and the debug unit's memory-dump sequencer.
- The pipeline normally has priority.
- The embedded dump engine walks all DEPTH words and streams them to the debug unit over a valid/ready handshake.
- A starvation counter guarantees dump progress by stalling the pipeline for one cycle when needed.

Parameters:
- DATA_WIDTH, 32: data and byte-address width.
- DEPTH, 32: number of words the dump covers (word index 0..DEPTH-1).
- STARVE_LIMIT, 4: consecutive denied dump cycles before the dump forcibly wins. 0 means the dump always wins.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_pipe_req  in  1  MEM stage accesses memory this cycle (load or store).
- i_pipe_write  in  1  store when 1 (i_mem[1] of the MEM control).
- i_pipe_address  in  DATA_WIDTH  byte address from the pipeline.
- i_pipe_datawrite  in  DATA_WIDTH  store data.
- o_pipe_dataread  out  DATA_WIDTH  load data, passthrough of i_mem_dataread.
- o_pipe_stall  out  1  pipeline must hold its request this cycle.
- i_dump_start  in  1  one-cycle pulse that starts a dump.
- i_dump_ready  in  1  debug unit accepts o_dump_data.
- o_dump_data  out  DATA_WIDTH  current dumped word.
- o_dump_valid  out  1  o_dump_data is valid.
- o_dump_busy  out  1  dump in progress.
- o_dump_done  out  1  one-cycle pulse after the last word is accepted.
- o_mem_address  out  DATA_WIDTH  to the memory.
- o_mem_datawrite  out  DATA_WIDTH  to the memory.
- o_mem_memwrite  out  1  to the memory.
- i_mem_dataread  in  DATA_WIDTH  from the memory; synchronous read, valid one cycle after the address.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, idx=0, starve_cnt=0.
  - o_dump_data=0; o_dump_valid, o_dump_busy, o_dump_done=0.
  - o_pipe_stall=0, o_mem_memwrite=0.
- FSM states:
  - IDLE: i_dump_start moves to ISSUE with idx=0 and starve_cnt=0.
  - ISSUE: the dump requests the memory (see Grant). On grant, the next state is CAPTURE.
  - CAPTURE: register i_mem_dataread into o_dump_data, then go to HOLD.
  - HOLD: o_dump_valid=1. On i_dump_ready:
    - if idx==DEPTH-1, go to DONE;
    - otherwise idx++ and go to ISSUE.
  - DONE: o_dump_done=1 for one cycle, then IDLE.
- o_dump_busy=1 in every state except IDLE.
- Grant, evaluated in ISSUE only:
  - dump_grant = !i_pipe_req || (starve_cnt >= STARVE_LIMIT).
  - If denied, starve_cnt increments, saturating at STARVE_LIMIT.
  - On grant, starve_cnt clears to 0.
- o_pipe_stall = (state==ISSUE) && i_pipe_req && (starve_cnt >= STARVE_LIMIT). It is combinational from registers and i_pipe_req. The pipeline holds its request and retries next cycle.
- Memory mux:
  - On a dump grant: o_mem_address = idx*4 (word index shifted left by 2, zero-extended to DATA_WIDTH), o_mem_memwrite=0, o_mem_datawrite=0.
  - Otherwise the pipeline drives all three memory signals, and o_mem_memwrite = i_pipe_req & i_pipe_write.
  - A stalled store is never written.
- o_pipe_dataread always equals i_mem_dataread. It is meaningful to the pipeline only the cycle after an unstalled pipeline read.
- Latency per word with no contention: ISSUE to CAPTURE to HOLD, so o_dump_valid rises 2 cycles after entering ISSUE.
- Boundaries:
  - i_dump_start is ignored while o_dump_busy=1.
  - i_dump_ready outside HOLD is ignored.
  - o_dump_data stays stable throughout HOLD.
  - idx is clog2(DEPTH) bits and never wraps; DONE is reached exactly at DEPTH-1.
  - Reset mid-dump aborts the dump: return to IDLE with no o_dump_done.
  - During IDLE, CAPTURE, HOLD and DONE the pipeline owns the memory unconditionally, and o_pipe_stall=0.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding constants ST_IDLE, ST_ISSUE, ST_CAPTURE, ST_HOLD, ST_DONE (3 bits);
  - the word-to-byte shift constant, 2.
- One natural sub-module, dump_sequencer: FSM, idx counter and starvation counter. It outputs dump_req, dump_addr and dump_grant_taken.
- The top level contains the grant logic and the memory mux.

Test Plan:
- Reset mid-run: assert i_reset during HOLD at idx=5, memory preloaded with word[i]=0x1000+i. Required: all outputs return to 0, no o_dump_done. A new start re-dumps from word 0 (0x1000).
- Idle pipeline, DEPTH=4, memory word[i]=0xA0+i, i_dump_ready=1: o_dump_valid carries 0xA0..0xA3 in order, one word every 3 cycles, then o_dump_done pulses once.
- Backpressure: hold i_dump_ready=0 for 10 cycles in HOLD. Required: o_dump_data remains 0xA0 and o_dump_valid remains 1, with no idx advance and no memory access by the dump.
- Continuous pipeline load, i_pipe_req=1 every cycle, STARVE_LIMIT=4:
  - the dump waits 4 cycles;
  - o_pipe_stall=1 for exactly 1 cycle, during which o_mem_address=idx*4;
  - starve_cnt returns to 0.
- Stalled store: i_pipe_write=1, address 0x40, data 0xDEAD during a stall cycle. Required: o_mem_memwrite=0 that cycle. The retried store next cycle writes, and a later dump of word 16 reads 0xDEAD.
- Start while busy: pulse i_dump_start at idx=2. Required: ignored, and the dump completes normally with a single o_dump_done.
